// File: rtl/bch_correct_if.sv
// Handshake and data bundle between the Chien search, the serial codeword
// source and the correction stage.
interface bch_correct_if #(
  parameter int DW = 2
) ();
  logic          in_valid;
  logic          in_data;
  logic          in_ready;
  logic          ch_start;
  logic          err;
  logic [DW-1:0] deg;
  logic          out_valid;
  logic          out_data;
  logic          out_last;
  logic          out_fail;
  logic          busy;

  modport master (
    output in_valid, in_data, ch_start, err, deg,
    input  in_ready, out_valid, out_data, out_last, out_fail, busy
  );

  modport slave (
    input  in_valid, in_data, ch_start, err, deg,
    output in_ready, out_valid, out_data, out_last, out_fail, busy
  );
endinterface

// File: rtl/bch_correct.sv
// Bit-serial BCH correction: buffers one codeword, XORs it with the Chien
// error flags on the way out and flags codewords whose error count != degree.
module bch_correct #(
  parameter int N  = 15,
  parameter int M  = 4,
  parameter int T  = 3,
  parameter int DW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  bch_correct_if.slave  bus
);
  // Codeword length can never exceed the field's multiplicative order.
  localparam int NMAX = (1 << M) - 1;
  localparam int NE   = (N <= NMAX) ? N : NMAX;
  localparam int AW   = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic [1:0] {S_LOAD, S_WAIT, S_CORR} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] wptr_reg, wptr_next;
  logic [AW-1:0] rptr_reg, rptr_next;
  logic [DW-1:0] cnt_reg, cnt_next;
  logic [DW-1:0] deg_reg, deg_next;
  logic          out_valid_reg, out_valid_next;
  logic          out_data_reg, out_data_next;
  logic          out_last_reg, out_last_next;
  logic          out_fail_reg, out_fail_next;
  logic          mem_reg [0:NE-1];

  logic          wr_en;
  logic          process;
  logic [DW-1:0] cnt_base;
  logic [DW-1:0] deg_eff;
  logic [DW-1:0] cnt_sum;

  always_comb begin
    state_next     = state_reg;
    wptr_next      = wptr_reg;
    rptr_next      = rptr_reg;
    cnt_next       = cnt_reg;
    deg_next       = deg_reg;
    out_valid_next = 1'b0;
    out_data_next  = 1'b0;
    out_last_next  = 1'b0;
    out_fail_next  = 1'b0;
    wr_en          = 1'b0;
    process        = 1'b0;
    cnt_base       = '0;
    deg_eff        = deg_reg;
    cnt_sum        = '0;

    case (state_reg)
      S_LOAD: begin
        if (bus.in_valid) begin
          wr_en = 1'b1;
          if (wptr_reg == AW'(NE - 1)) begin
            wptr_next  = '0;
            state_next = S_WAIT;
          end else begin
            wptr_next = wptr_reg + AW'(1);
          end
        end
      end
      S_WAIT: begin
        if (bus.ch_start) begin
          process  = 1'b1;
          deg_next = bus.deg;
        end
      end
      S_CORR:  process = 1'b1;
      default: state_next = S_LOAD;
    endcase

    if (process) begin
      // Position 0 is handled on the ch_start cycle itself, before the
      // count and degree registers have been reloaded.
      cnt_base = (state_reg == S_WAIT) ? '0 : cnt_reg;
      deg_eff  = (state_reg == S_WAIT) ? bus.deg : deg_reg;
      cnt_sum  = (bus.err && (int'(cnt_base) < T)) ? cnt_base + DW'(1) : cnt_base;
      cnt_next       = cnt_sum;
      out_valid_next = 1'b1;
      out_data_next  = mem_reg[rptr_reg] ^ bus.err;
      if (rptr_reg == AW'(NE - 1)) begin
        out_last_next = 1'b1;
        out_fail_next = (cnt_sum != deg_eff) || (int'(deg_eff) > T);
        rptr_next     = '0;
        state_next    = S_LOAD;
      end else begin
        rptr_next  = rptr_reg + AW'(1);
        state_next = S_CORR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_LOAD;
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      cnt_reg       <= '0;
      deg_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= 1'b0;
      out_last_reg  <= 1'b0;
      out_fail_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      wptr_reg      <= wptr_next;
      rptr_reg      <= rptr_next;
      cnt_reg       <= cnt_next;
      deg_reg       <= deg_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_last_reg  <= out_last_next;
      out_fail_reg  <= out_fail_next;
    end
  end

  // Buffer contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wptr_reg] <= bus.in_data;
  end

  assign bus.in_ready  = (state_reg == S_LOAD);
  assign bus.busy      = (state_reg != S_LOAD) || (wptr_reg != '0);
  assign bus.out_valid = out_valid_reg;
  assign bus.out_data  = out_data_reg;
  assign bus.out_last  = out_last_reg;
  assign bus.out_fail  = out_fail_reg;
endmodule

// File: tb/tb_bch_correct.sv
// Self-checking bench for bch_correct: directed vector table, randomized
// codewords against a popcount-based model, and a mid-correction reset.
module tb_bch_correct;
  localparam int N  = 15;
  localparam int T  = 3;
  localparam int DW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bch_correct_if #(.DW(DW)) bif ();

  bch_correct #(.N(N), .M(4), .T(T), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [14:0]   data;
    logic [14:0]   errs;
    logic [DW-1:0] deg;
    bit            gapped;
    bit            spurious;
    bit            hold;
    logic [14:0]   exp_out;
    logic          exp_fail;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: corrected word is data ^ error mask; codeword fails when the
  // number of flagged positions (capped at T) differs from the degree.
  function automatic void model(input logic [14:0] d, input logic [14:0] e,
                                input logic [DW-1:0] g,
                                output logic [14:0] o, output logic f);
    int n;
    n = 0;
    for (int i = 0; i < N; i++) if (e[i]) n++;
    if (n > T) n = T;
    o = d ^ e;
    f = (n != int'(g)) || (int'(g) > T);
  endfunction

  task automatic load_word(input logic [14:0] w, input bit gapped, input bit spurious, input bit hold);
    for (int i = 0; i < N; i++) begin
      check("in_ready_load", bif.in_ready, 1);
      bif.in_valid = 1'b1;
      bif.in_data  = w[i];
      bif.ch_start = spurious && (i == 4);
      tick();
      if (gapped) begin
        bif.in_valid = 1'b0;
        bif.in_data  = ~w[i];
        bif.ch_start = 1'b0;
        tick();
      end
    end
    bif.ch_start = 1'b0;
    bif.in_valid = hold;
    bif.in_data  = 1'($urandom);
    check("in_ready_full", bif.in_ready, 0);
    check("busy_full", bif.busy, 1);
  endtask

  task automatic run_corr(input logic [14:0] w, input logic [14:0] e, input logic [DW-1:0] g,
                          input logic [14:0] exp_o, input logic exp_f, input string tag);
    logic [14:0] got;
    got = '0;
    for (int i = 0; i < 2; i++) begin
      bif.in_data = 1'($urandom);
      tick();
      check("wait_idle", {bif.out_valid, bif.in_ready, bif.busy}, 3'b001);
    end
    bif.ch_start = 1'b1;
    bif.deg      = g;
    bif.err      = e[0];
    tick();
    for (int k = 0; k < N; k++) begin
      got[k] = bif.out_data;
      check($sformatf("%s_pos%0d", tag, k),
            {bif.out_valid, bif.out_data, bif.out_last, bif.out_fail},
            {1'b1, exp_o[k], (k == N - 1), (k == N - 1) ? exp_f : 1'b0});
      check($sformatf("%s_in_ready%0d", tag, k), bif.in_ready, (k == N - 1));
      bif.ch_start = (k == 5);
      bif.deg      = DW'($urandom);
      bif.err      = (k + 1 < N) ? e[k + 1] : 1'b0;
      bif.in_data  = 1'($urandom);
      if (k == N - 1) bif.in_valid = 1'b0;
      tick();
    end
    bif.ch_start = 1'b0;
    bif.err      = 1'b0;
    bif.in_valid = 1'b0;
    check($sformatf("%s_idle", tag),
          {bif.out_valid, bif.out_data, bif.out_last, bif.out_fail, bif.in_ready}, 5'b00001);
    $display("codeword %s data=%h err=%h deg=%0d out=%h fail_exp=%0d", tag, w, e, g, got, exp_f);
  endtask

  vec_t tbl [7];

  initial begin
    logic [14:0]   rd, re, ro;
    logic [DW-1:0] rg;
    logic          rf;

    tbl[0] = '{15'h5A3C, 15'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 15'h5A3C, 1'b0};
    tbl[1] = '{15'h5A3C, 15'h4081, 2'd3, 1'b0, 1'b0, 1'b1, 15'h1ABD, 1'b0};
    tbl[2] = '{15'h5A3C, 15'h0020, 2'd2, 1'b0, 1'b1, 1'b0, 15'h5A1C, 1'b1};
    tbl[3] = '{15'h3C5A, 15'h0000, 2'd0, 1'b1, 1'b0, 1'b0, 15'h3C5A, 1'b0};
    tbl[4] = '{15'h7FFF, 15'h000F, 2'd3, 1'b0, 1'b0, 1'b0, 15'h7FF0, 1'b0};
    tbl[5] = '{15'h0000, 15'h4000, 2'd0, 1'b0, 1'b0, 1'b0, 15'h4000, 1'b1};
    tbl[6] = '{15'h1234, 15'h4000, 2'd1, 1'b0, 1'b1, 1'b1, 15'h5234, 1'b0};

    bif.in_valid = 1'b0;
    bif.in_data  = 1'b0;
    bif.ch_start = 1'b0;
    bif.err      = 1'b0;
    bif.deg      = '0;

    #12;
    check("reset_state",
          {bif.in_ready, bif.out_valid, bif.out_data, bif.out_last, bif.out_fail, bif.busy}, 6'b100000);
    rst_n = 1'b1;
    tick();

    for (int v = 0; v < 7; v++) begin
      load_word(tbl[v].data, tbl[v].gapped, tbl[v].spurious, tbl[v].hold);
      run_corr(tbl[v].data, tbl[v].errs, tbl[v].deg, tbl[v].exp_out, tbl[v].exp_fail,
               $sformatf("vec%0d", v));
    end

    for (int r = 0; r < 12; r++) begin
      rd = 15'($urandom);
      re = '0;
      for (int i = 0; i < N; i++) re[i] = ($urandom_range(7) == 0);
      rg = DW'($urandom_range(3));
      model(rd, re, rg, ro, rf);
      load_word(rd, (r % 3 == 0), (r % 2 == 0), (r % 4 == 1));
      run_corr(rd, re, rg, ro, rf, $sformatf("rnd%0d", r));
    end

    // Reset while output position 6 is on the bus.
    load_word(15'h2B6D, 1'b0, 1'b0, 1'b0);
    tick();
    bif.ch_start = 1'b1;
    bif.deg      = '0;
    bif.err      = 1'b0;
    tick();
    bif.ch_start = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    check("pre_reset_pos6", {bif.out_valid, bif.out_data, bif.out_last}, {1'b1, 1'b1, 1'b0});
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {bif.out_valid, bif.out_data, bif.out_last, bif.out_fail, bif.busy, bif.in_ready}, 6'b000001);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_reset_idle",
            {bif.out_valid, bif.out_last, bif.in_ready, bif.busy}, 4'b0010);
    end
    $display("codeword reset_abort data=2b6d aborted at position 6");
    load_word(tbl[0].data, 1'b0, 1'b0, 1'b0);
    run_corr(tbl[0].data, tbl[0].errs, tbl[0].deg, tbl[0].exp_out, tbl[0].exp_fail, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bch_correct.md
Name: bch_correct

Overview:
- Bit-serial error-correction stage sitting directly downstream of the Chien search.
- Buffers one received codeword and releases it one bit at a time, XORing each bit with the Chien error flag for the same position.
- Counts the corrections made and compares the count with the error-locator degree from the key-equation solver. A mismatch marks the codeword uncorrectable.

Parameters:
- N, 15, codeword length in bits (N <= 2^M - 1).
- M, 4, field width; used only for N bounds checking.
- T, 3, maximum correctable errors.
- DW, 2, width of the degree and count fields, equal to clog2(T+1).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  serial codeword bit present on in_data.
- in_data  in  1  received bit; bit 0 (the first bit sent) arrives first.
- in_ready  out  1  buffer can accept a bit.
- ch_start  in  1  one-cycle pulse; Chien output for position 0 is valid on this cycle.
- err  in  1  Chien error flag for the current position.
- deg  in  DW  error-locator degree; sampled on ch_start.
- out_valid  out  1  out_data valid.
- out_data  out  1  corrected bit.
- out_last  out  1  marks position N-1.
- out_fail  out  1  valid with out_last; 1 = uncorrectable.
- busy  out  1  any state other than LOAD with an empty buffer.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state=LOAD; write pointer, read pointer and error count = 0.
  - in_ready=1; out_valid, out_data, out_last, out_fail, busy = 0.
- Buffer: N-bit register array with a write pointer and a read pointer, each 0..N-1.
- State LOAD:
  - A bit is accepted when in_valid && in_ready.
  - buf[wptr]<=in_data; wptr increments.
  - On the accept with wptr==N-1: wptr<=0, in_ready<=0 from the next cycle, state->WAIT.
- State WAIT:
  - in_ready=0.
  - On ch_start: latch deg, cnt<=0, rptr<=0, state->CORR. Position 0 is processed on this same cycle.
- State CORR (also applies to the ch_start cycle in WAIT):
  - Each cycle processes rptr. Err is valid on consecutive cycles with no gaps.
  - Registered outputs, 1-cycle latency from the position's err cycle:
    - out_data<=buf[rptr]^err
    - out_valid<=1
    - out_last<=(rptr==N-1)
  - cnt increments when err=1 and saturates at T.
- Completion, on the rptr==N-1 cycle:
  - out_fail<=((cnt+err)!=deg_latched) || (deg_latched>T), using the saturated sum.
  - state->LOAD; in_ready<=1 next cycle.
  - out_valid drops after one further cycle unless a new codeword is already being corrected.
- Outputs:
  - out_fail is 0 whenever out_last=0.
  - out_valid/out_data/out_last/out_fail are held 0 outside CORR output cycles.
- Boundary conditions:
  - ch_start during LOAD or CORR is ignored and does not restart a codeword.
  - in_valid while in_ready=0 is ignored; no buffer write occurs.
  - Loading of the next codeword and CORR are not overlapped. The buffer is single-bank, so in_ready stays 0 from the last load bit until the N-1 output cycle.
  - deg=0 with no err pulses gives out_fail=0; the data passes through unchanged.
  - Reset asserted mid-CORR aborts immediately. Outputs go to 0, no out_last is produced, and buffer contents are don't-care.
- Width rules:
  - wptr and rptr are clog2(N) bits.
  - cnt is DW bits; comparison is unsigned.
- Throughput: one codeword per N load cycles + WAIT latency + N correction cycles.

Test Plan:
- Clean codeword:
  - Stimulus: N=15; load 15'h5A3C bits; ch_start with deg=0; err=0 for all cycles.
  - Response: out_data stream equals the input, out_last on the 15th output, out_fail=0.
- Three errors:
  - Stimulus: err=1 at positions 0, 7 and 14; deg=3.
  - Response: exactly those output bits inverted, out_fail=0.
- Degree mismatch:
  - Stimulus: deg=2; err=1 at a single position (5).
  - Response: bit 5 inverted, out_fail=1 on the out_last cycle only.
- Handshake:
  - Stimulus: in_valid held high throughout.
  - Response: in_ready drops after the 15th accept and stays 0 through WAIT and CORR. A spurious ch_start during LOAD has no effect. in_ready returns to 1 the cycle after the last output.
- Gapped input:
  - Stimulus: in_valid toggling 1,0,1,0 during LOAD.
  - Response: only the valid bits are stored; the output order is preserved.
- Reset mid-CORR:
  - Stimulus: rst_n=0 at output position 6.
  - Response: all outputs 0 asynchronously, in_ready=1 after release. A following clean codeword is corrected normally.
